line_fill_ctrl: RTL and testbench
=================================

Name: line_fill_ctrl

Overview:
- Downstream main-memory stage for the split I/D cache.
- Owns the 4096 x 128-bit main-memory array.
- Services line refills and dirty-victim writebacks from both caches over a req/ack handshake, with fixed multi-cycle memory latency.
- Round-robin arbitration between the I and D ports; one transaction in flight at a time.

Parameters:
LINE_W, 128, line width in bits (8 x 16-bit words)
LADDR_W, 12, line address width (word address bits [14:3])
DEPTH, 4096, lines in main memory
WB_LAT, 4, cycles per line write (≥1)
RD_LAT, 4, cycles per line read (≥1)
INIT_FILE, "", optional $readmemh image for the array; empty means no preload

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
i_req  in  1  I-cache request; held with stable fields until i_ack
i_wb  in  1  request includes victim writeback before fill
i_wb_addr  in  LADDR_W  victim line address
i_wb_data  in  LINE_W  victim line data
i_fill_addr  in  LADDR_W  line to fetch
i_ack  out  1  one-cycle completion pulse
i_rdata  out  LINE_W  fill data, valid while i_ack=1
d_req, d_wb, d_wb_addr, d_wb_data, d_fill_addr, d_ack, d_rdata: same semantics for the D-cache port
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at an edge):
  - state→IDLE; i_ack=d_ack=0; i_rdata=d_rdata=0; busy=0; counter=0; last_grant=D (so I wins the first tie).
  - Memory array is not cleared.
- FSM states: IDLE, WB, FILL, DONE.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port opposite last_grant.
  - At grant, register port id, wb flag, wb_addr, wb_data and fill_addr. Ungranted port inputs are ignored thereafter.
  - Next state is WB if wb=1, else FILL. Update last_grant.
- WB: count WB_LAT cycles. On the last cycle write wb_data into mem[wb_addr], then go to FILL with counter=0.
- FILL: count RD_LAT cycles. On the last cycle latch mem[fill_addr] into the granted port's rdata, then go to DONE.
- DONE:
  - Assert the granted port's ack for exactly one cycle; rdata is held until that port's next ack.
  - Next state is IDLE. A new grant may occur on the edge following DONE; there is no back-to-back grant in the DONE cycle.
- Latency: grant at edge k → ack high in cycle k+1+RD_LAT+(wb?WB_LAT:0). Defaults: 5 cycles (no wb), 9 cycles (wb).
- Requester drops req in the cycle after ack. A req still high in IDLE is treated as a new request.
- wb_addr == fill_addr: the write completes before the read, so the fill returns the written data.
- Port ordering: a D writeback followed by an I fill of the same line returns the new data; memory is coherent via serialisation.
- Reset mid-operation:
  - Any in-flight transaction is abandoned with no ack.
  - A writeback not yet at its last WB cycle is not performed.
  - Requester must re-issue.
- Address width: DEPTH=2^LADDR_W, so there are no out-of-range addresses. The counter is $clog2(max(WB_LAT,RD_LAT)+1) bits.
- Never both acks high in the same cycle; ack never asserted outside DONE.

Decomposition:
- Package line_fill_pkg:
  - state enum (IDLE/WB/FILL/DONE);
  - LINE_W/LADDR_W defaults;
  - PORT_I=0/PORT_D=1 grant constants.
- One sub-module: rr_arb2 (2-way round-robin arbiter, registered last_grant, grant-enable input).
- Memory array, counter and FSM stay in the top.

Test Plan:
- Reset then i_req, i_fill_addr=12'h005, i_wb=0, with mem[5]=128'hA5A5... preloaded → i_ack high exactly 5 cycles after grant, i_rdata=mem[5]; d_ack stays 0.
- d_req, d_wb=1, d_wb_addr=12'h010, d_wb_data=128'h1234, d_fill_addr=12'h010 → d_ack after 9 cycles, d_rdata=128'h1234; follow-up i fill of 12'h010 returns 128'h1234.
- i_req and d_req asserted in the same cycle, both held → I served first; D granted the cycle after I's DONE; then a simultaneous pair → D first (round-robin alternation).
- Reset asserted during WB of d_wb to addr 12'h020 with data 128'hFFFF → no d_ack; mem[0x20] unchanged; busy=0 the cycle after reset.
- req held high one cycle past ack with a new fill_addr=12'h003 → second transaction granted from IDLE and returns mem[3]; busy is low only in IDLE cycles.
- Boundary addresses fill 12'hFFF and writeback 12'h000 → correct data, no aliasing.

Source files
------------

// File: rtl/line_fill_pkg.sv
// Shared types and constants for the main-memory line fill controller.
//   state_e      : controller FSM states
//   LINE_W_DEF   : default line width in bits (8 x 16-bit words)
//   LADDR_W_DEF  : default line address width
//   PORT_I/PORT_D: grant identifiers for the I-cache and D-cache ports
//   max2         : helper used to size the shared latency counter
package line_fill_pkg;

  localparam int unsigned LINE_W_DEF  = 128;
  localparam int unsigned LADDR_W_DEF = 12;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/line_fill_ctrl_rr_arb2.sv
// Two-way round-robin arbiter between the I and D cache ports.
//   clk, rst  : clock, synchronous active-high reset (last grant -> D)
//   en        : grant enable; last_grant only advances when en && gnt_valid
//   req_i     : I-port request
//   req_d     : D-port request
//   gnt_valid : at least one request present
//   gnt_port  : winning port (PORT_I / PORT_D), valid when gnt_valid
module rr_arb2
  import line_fill_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_i,
  input  logic req_d,
  output logic gnt_valid,
  output logic gnt_port
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt_valid = req_i | req_d;
    // On a tie the port that did not win last time is chosen.
    if (req_i && req_d) begin
      gnt_port = ~last_grant_q;
    end else if (req_d) begin
      gnt_port = PORT_D;
    end else begin
      gnt_port = PORT_I;
    end
    last_grant_d = (en && gnt_valid) ? gnt_port : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= PORT_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/line_fill_ctrl.sv
// Main-memory stage behind the split I/D cache. Owns the line array and
// services refills, optionally preceded by a dirty-victim writeback, for
// one port at a time with fixed write/read latencies.
//   clk, rst                 : clock, synchronous active-high reset
//   i_req / d_req            : request, held with stable fields until ack
//   i_wb / d_wb              : writeback victim before the fill
//   i_wb_addr / d_wb_addr    : victim line address
//   i_wb_data / d_wb_data    : victim line data
//   i_fill_addr / d_fill_addr: line to fetch
//   i_ack / d_ack            : one-cycle completion pulse
//   i_rdata / d_rdata        : fill data, held until that port's next ack
//   busy                     : controller is not idle
// INIT_FILE names an optional preload image for the array; the array
// contents are never cleared by reset.
module line_fill_ctrl
  import line_fill_pkg::*;
#(
  parameter int unsigned LINE_W    = LINE_W_DEF,
  parameter int unsigned LADDR_W   = LADDR_W_DEF,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned WB_LAT    = 4,
  parameter int unsigned RD_LAT    = 4,
  parameter string       INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic               i_wb,
  input  logic [LADDR_W-1:0] i_wb_addr,
  input  logic [LINE_W-1:0]  i_wb_data,
  input  logic [LADDR_W-1:0] i_fill_addr,
  output logic               i_ack,
  output logic [LINE_W-1:0]  i_rdata,
  input  logic               d_req,
  input  logic               d_wb,
  input  logic [LADDR_W-1:0] d_wb_addr,
  input  logic [LINE_W-1:0]  d_wb_data,
  input  logic [LADDR_W-1:0] d_fill_addr,
  output logic               d_ack,
  output logic [LINE_W-1:0]  d_rdata,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(max2(WB_LAT, RD_LAT) + 1);
  localparam logic [CNT_W-1:0] WB_LAST = CNT_W'(WB_LAT - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               port_q,      port_d;
  logic [LADDR_W-1:0] wb_addr_q,   wb_addr_d;
  logic [LINE_W-1:0]  wb_data_q,   wb_data_d;
  logic [LADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic               i_ack_q,     i_ack_d;
  logic               d_ack_q,     d_ack_d;
  logic [LINE_W-1:0]  i_rdata_q,   i_rdata_d;
  logic [LINE_W-1:0]  d_rdata_q,   d_rdata_d;
  logic               busy_q,      busy_d;

  logic               gnt_valid;
  logic               gnt_port;
  logic               arb_en;
  logic               sel_wb;
  logic               mem_we;
  logic [LINE_W-1:0]  mem_rd;

  logic [LINE_W-1:0]  mem [DEPTH];

  assign arb_en = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .req_i     (i_req),
    .req_d     (d_req),
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );

  assign sel_wb = (gnt_port == PORT_D) ? d_wb : i_wb;
  assign mem_rd = mem[fill_addr_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    port_d      = port_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    fill_addr_d = fill_addr_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_we      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          // The winner's fields are captured here; the other port is
          // ignored until the controller returns to idle.
          port_d      = gnt_port;
          wb_addr_d   = (gnt_port == PORT_D) ? d_wb_addr   : i_wb_addr;
          wb_data_d   = (gnt_port == PORT_D) ? d_wb_data   : i_wb_data;
          fill_addr_d = (gnt_port == PORT_D) ? d_fill_addr : i_fill_addr;
          cnt_d       = '0;
          state_d     = sel_wb ? ST_WB : ST_FILL;
        end
      end
      ST_WB: begin
        if (cnt_q == WB_LAST) begin
          mem_we  = 1'b1;
          cnt_d   = '0;
          state_d = ST_FILL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FILL: begin
        if (cnt_q == RD_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
          if (port_q == PORT_D) begin
            d_rdata_d = mem_rd;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = mem_rd;
            i_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered so busy lines up with the state it describes.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      port_q      <= PORT_I;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      fill_addr_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      port_q      <= port_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      fill_addr_q <= fill_addr_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Array is not reset; a reset coinciding with the final WB cycle
  // abandons the write along with the rest of the transaction.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[wb_addr_q] <= wb_data_q;
    end
  end

  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Self-checking bench for line_fill_ctrl: directed scenarios followed by
// randomized single and contending requests, checked against a line-level
// memory model with round-robin ordering.
module tb_line_fill_ctrl;

  localparam int unsigned LW  = 128;
  localparam int unsigned AW  = 12;
  localparam int unsigned WBL = 4;
  localparam int unsigned RDL = 4;

  typedef struct packed {
    logic          wb;
    logic [AW-1:0] wa;
    logic [LW-1:0] wd;
    logic [AW-1:0] fa;
  } req_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_wb, d_req, d_wb;
  logic [AW-1:0] i_wb_addr, i_fill_addr, d_wb_addr, d_fill_addr;
  logic [LW-1:0] i_wb_data, d_wb_data;
  logic          i_ack, d_ack, busy;
  logic [LW-1:0] i_rdata, d_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: line contents, written-line list, last served port,
  // and the rdata each port should currently be holding.
  logic [LW-1:0] mdl [int];
  int            written [$];
  bit            mdl_last;
  logic [LW-1:0] last_rd [2];

  always #5 clk = ~clk;

  line_fill_ctrl #(
    .LINE_W    (LW),
    .LADDR_W   (AW),
    .DEPTH     (4096),
    .WB_LAT    (WBL),
    .RD_LAT    (RDL),
    .INIT_FILE ("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_wb        (i_wb),
    .i_wb_addr   (i_wb_addr),
    .i_wb_data   (i_wb_data),
    .i_fill_addr (i_fill_addr),
    .i_ack       (i_ack),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_wb        (d_wb),
    .d_wb_addr   (d_wb_addr),
    .d_wb_data   (d_wb_data),
    .d_fill_addr (d_fill_addr),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input logic wb);
    return 1 + RDL + (wb ? WBL : 0);
  endfunction

  // Serve one request in the model: write first, then read.
  function automatic logic [LW-1:0] model_txn(input req_t r);
    if (r.wb) begin
      mdl[int'(r.wa)] = r.wd;
      written.push_back(int'(r.wa));
    end
    return mdl[int'(r.fa)];
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic req_t gen_req();
    req_t r;
    r.wb = 1'($urandom_range(0, 1));
    r.wa = AW'($urandom);
    r.wd = rnd_line();
    if (r.wb && ($urandom_range(0, 1) == 1))
      r.fa = r.wa;
    else
      r.fa = AW'(written[$urandom_range(0, written.size() - 1)]);
    return r;
  endfunction

  task automatic set_req(input bit port, input req_t r);
    if (port) begin
      d_wb = r.wb; d_wb_addr = r.wa; d_wb_data = r.wd; d_fill_addr = r.fa; d_req = 1'b1;
    end else begin
      i_wb = r.wb; i_wb_addr = r.wa; i_wb_data = r.wd; i_fill_addr = r.fa; i_req = 1'b1;
    end
  endtask

  // Waits for the port's ack; gap = negedge index at which busy first rose.
  task automatic wait_ack(input bit port, input int exp_lat, input logic [LW-1:0] exp_data,
                          input bit hold, output int gap);
    int n, first;
    bit seen, other_seen, busy_drop;
    n = 0; first = 0; seen = 0; other_seen = 0; busy_drop = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (first == 0 && busy) first = n;
      if (first != 0 && !busy) busy_drop = 1;
      if (port ? i_ack : d_ack) other_seen = 1;
      if (port ? d_ack : i_ack) seen = 1;
    end
    gap = first;
    chk("ack_seen", 128'(seen), 128'(1));
    if (seen) begin
      chk("ack_latency", 128'(n - first + 1), 128'(exp_lat));
      chk(port ? "d_rdata" : "i_rdata", port ? d_rdata : i_rdata, exp_data);
      chk("other_ack_quiet", 128'(other_seen), 128'(0));
      chk("busy_held", 128'(busy_drop), 128'(0));
      chk("other_rdata_held", port ? i_rdata : d_rdata, last_rd[!port]);
      last_rd[port] = exp_data;
      if (!hold) begin
        if (port) d_req = 1'b0; else i_req = 1'b0;
      end
    end
  endtask

  task automatic txn(input bit port, input req_t r);
    logic [LW-1:0] e;
    int g;
    set_req(port, r);
    e = model_txn(r);
    mdl_last = port;
    wait_ack(port, lat(r.wb), e, 1'b0, g);
  endtask

  task automatic dual(input req_t ri, input req_t rd);
    bit w;
    logic [LW-1:0] ew, el;
    int g;
    set_req(1'b0, ri);
    set_req(1'b1, rd);
    w  = !mdl_last;
    ew = model_txn(w ? rd : ri);
    el = model_txn(w ? ri : rd);
    mdl_last = !w;
    wait_ack(w, lat(w ? rd.wb : ri.wb), ew, 1'b0, g);
    wait_ack(!w, lat(w ? ri.wb : rd.wb), el, 1'b0, g);
    chk("rr_regrant_gap", 128'(g), 128'(2));
  endtask

  function automatic req_t mk(input logic wb, input logic [AW-1:0] wa,
                              input logic [LW-1:0] wd, input logic [AW-1:0] fa);
    req_t r;
    r.wb = wb; r.wa = wa; r.wd = wd; r.fa = fa;
    return r;
  endfunction

  initial begin
    logic [LW-1:0] e1, e2, v20;
    int g;
    bit stray;

    rst = 1'b1;
    i_req = 0; i_wb = 0; i_wb_addr = '0; i_wb_data = '0; i_fill_addr = '0;
    d_req = 0; d_wb = 0; d_wb_addr = '0; d_wb_data = '0; d_fill_addr = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    mdl_last = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_i_ack", 128'(i_ack), 128'(0));
    chk("rst_d_ack", 128'(d_ack), 128'(0));
    chk("rst_i_rdata", i_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    rst = 1'b0;

    // Preload line 5 through a writeback, then a plain 5-cycle fill.
    txn(1'b0, mk(1'b1, 12'h005, {8{16'hA5A5}}, 12'h005));
    txn(1'b0, mk(1'b0, 12'h000, '0, 12'h005));

    // Writeback and fill of the same line, then the other port sees it.
    txn(1'b1, mk(1'b1, 12'h010, 128'h1234, 12'h010));
    txn(1'b0, mk(1'b0, 12'h000, '0, 12'h010));

    // Contention: after a D service I wins the tie; after an I service D wins.
    txn(1'b0, mk(1'b1, 12'h030, rnd_line(), 12'h030));
    txn(1'b1, mk(1'b1, 12'h031, rnd_line(), 12'h031));
    dual(mk(1'b0, 12'h000, '0, 12'h030), mk(1'b0, 12'h000, '0, 12'h031));
    txn(1'b0, mk(1'b0, 12'h000, '0, 12'h005));
    dual(mk(1'b0, 12'h000, '0, 12'h031), mk(1'b1, 12'h032, rnd_line(), 12'h030));

    // Reset in the middle of a D writeback: no ack, line 0x20 untouched.
    v20 = rnd_line();
    txn(1'b0, mk(1'b1, 12'h020, v20, 12'h020));
    set_req(1'b1, mk(1'b1, 12'h020, 128'hFFFF, 12'h021));
    @(negedge clk);
    @(negedge clk);
    chk("busy_in_wb", 128'(busy), 128'(1));
    rst = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_d_ack", 128'(d_ack), 128'(0));
    chk("midrst_d_rdata", d_rdata, '0);
    chk("midrst_i_rdata", i_rdata, '0);
    last_rd[0] = '0; last_rd[1] = '0;
    mdl_last = 1'b1;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (d_ack || i_ack || busy) stray = 1;
    end
    chk("midrst_quiet", 128'(stray), 128'(0));
    txn(1'b0, mk(1'b0, 12'h000, '0, 12'h020));

    // Request held past ack with a new address is a fresh request from idle.
    txn(1'b1, mk(1'b1, 12'h003, rnd_line(), 12'h003));
    set_req(1'b0, mk(1'b0, 12'h000, '0, 12'h010));
    e1 = model_txn(mk(1'b0, 12'h000, '0, 12'h010));
    wait_ack(1'b0, lat(1'b0), e1, 1'b1, g);
    i_fill_addr = 12'h003;
    e2 = model_txn(mk(1'b0, 12'h000, '0, 12'h003));
    mdl_last = 1'b0;
    wait_ack(1'b0, lat(1'b0), e2, 1'b0, g);
    chk("held_regrant_gap", 128'(g), 128'(2));

    // Address extremes.
    txn(1'b0, mk(1'b1, 12'hFFF, rnd_line(), 12'hFFF));
    txn(1'b1, mk(1'b1, 12'h000, rnd_line(), 12'hFFF));
    txn(1'b0, mk(1'b0, 12'h000, '0, 12'h000));
    txn(1'b1, mk(1'b0, 12'h000, '0, 12'hFFF));

    // Randomized traffic with random idle spacing.
    for (int it = 0; it < 24; it++) begin
      int mode;
      mode = $urandom_range(0, 2);
      if (mode == 2) dual(gen_req(), gen_req());
      else txn(1'(mode), gen_req());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
